// File: rtl/prga_encrypt.sv
// RC4 keystream encryptor: reads a length-prefixed plaintext and a KSA-initialised S memory,
// then writes the length-prefixed ciphertext CT[k] = PT[k] ^ pad[k] through single-port RAMs.
module prga_encrypt #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic              rdy,
  output logic [ADDR_W-1:0] s_addr,
  input  logic [DATA_W-1:0] s_rddata,
  output logic [DATA_W-1:0] s_wrdata,
  output logic              s_wren,
  output logic [ADDR_W-1:0] pt_addr,
  input  logic [DATA_W-1:0] pt_rddata,
  output logic [ADDR_W-1:0] ct_addr,
  output logic [DATA_W-1:0] ct_wrdata,
  output logic              ct_wren
);

  typedef enum logic [3:0] {
    IDLE,
    RD_LEN,
    WAIT_LEN,
    WR_LEN,
    RD_I,
    WAIT_I,
    RD_J,
    WAIT_J,
    WR_I,
    WR_J,
    RD_P,
    WAIT_P,
    WR_CT
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] i;
  logic [DATA_W-1:0] j;
  logic [DATA_W-1:0] k;
  logic [DATA_W-1:0] len;
  logic [DATA_W-1:0] si;
  logic [DATA_W-1:0] sj;

  logic [DATA_W-1:0] i_inc;
  logic [DATA_W-1:0] j_sum;
  logic [DATA_W-1:0] pad_idx;

  always_comb begin
    i_inc   = i + 1'b1;
    j_sum   = j + s_rddata;
    pad_idx = si + sj;
  end

  // Outputs are registered, so each state's address/data is loaded on the edge that enters it;
  // i and j advance on that same edge, and pad/pt bytes are XORed straight into ct_wrdata.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      i         <= '0;
      j         <= '0;
      k         <= '0;
      len       <= '0;
      si        <= '0;
      sj        <= '0;
      rdy       <= 1'b0;
      s_addr    <= '0;
      s_wrdata  <= '0;
      s_wren    <= 1'b0;
      pt_addr   <= '0;
      ct_addr   <= '0;
      ct_wrdata <= '0;
      ct_wren   <= 1'b0;
    end else begin
      s_addr    <= '0;
      s_wrdata  <= '0;
      s_wren    <= 1'b0;
      pt_addr   <= '0;
      ct_addr   <= '0;
      ct_wrdata <= '0;
      ct_wren   <= 1'b0;
      rdy       <= 1'b0;
      unique case (state)
        IDLE: begin
          if (rdy && en) begin
            state <= RD_LEN;
            i     <= '0;
            j     <= '0;
            k     <= '0;
          end else begin
            rdy <= 1'b1;
          end
        end
        RD_LEN: state <= WAIT_LEN;
        WAIT_LEN: begin
          len       <= pt_rddata;
          ct_wrdata <= pt_rddata;
          ct_wren   <= 1'b1;
          state     <= WR_LEN;
        end
        WR_LEN: begin
          k <= DATA_W'(1);
          if (len == '0) begin
            state <= IDLE;
          end else begin
            i      <= i_inc;
            s_addr <= ADDR_W'(i_inc);
            state  <= RD_I;
          end
        end
        RD_I: state <= WAIT_I;
        WAIT_I: begin
          si     <= s_rddata;
          j      <= j_sum;
          s_addr <= ADDR_W'(j_sum);
          state  <= RD_J;
        end
        RD_J: state <= WAIT_J;
        WAIT_J: begin
          sj       <= s_rddata;
          s_addr   <= ADDR_W'(i);
          s_wrdata <= s_rddata;
          s_wren   <= 1'b1;
          state    <= WR_I;
        end
        WR_I: begin
          s_addr   <= ADDR_W'(j);
          s_wrdata <= si;
          s_wren   <= 1'b1;
          state    <= WR_J;
        end
        WR_J: begin
          s_addr  <= ADDR_W'(pad_idx);
          pt_addr <= ADDR_W'(k);
          state   <= RD_P;
        end
        RD_P: state <= WAIT_P;
        WAIT_P: begin
          ct_addr   <= ADDR_W'(k);
          ct_wrdata <= pt_rddata ^ s_rddata;
          ct_wren   <= 1'b1;
          state     <= WR_CT;
        end
        WR_CT: begin
          k <= k + 1'b1;
          if (k == len) begin
            state <= IDLE;
          end else begin
            i      <= i_inc;
            s_addr <= ADDR_W'(i_inc);
            state  <= RD_I;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
